axi_apb_bridge: RTL and testbench
=================================

# axi_apb_bridge

AXI4-Lite slave to APB4 master bridge, placed directly downstream of `axi_master` in place of a memory slave. It accepts single-beat write (AW/W/B) and read (AR/R) transactions and converts each one into exactly one APB SETUP/ACCESS transfer. It returns the APB completion status as the AXI response, which lets the existing master drive APB-attached peripherals.

## Interface
- `ADDR_W`, 32, address width on AXI and APB
- `DATA_W`, 32, data width; strobe width is `DATA_W/8`
- `TIMEOUT`, 16, maximum ACCESS cycles without PREADY; used only when the timeout feature is compiled in
- `ACLK` in 1: single clock; everything samples on the rising edge
- `ARESET` in 1: asynchronous, active-low reset
- `AWADDR` in ADDR_W; `AWVALID` in 1; `AWREADY` out 1: write-address channel
- `WDATA` in DATA_W; `WSTRB` in DATA_W/8; `WVALID` in 1; `WREADY` out 1: write-data channel
- `BRESP` out 1 (0=OKAY, 1=SLVERR); `BVALID` out 1; `BREADY` in 1: write-response channel
- `ARADDR` in ADDR_W; `ARVALID` in 1; `ARREADY` out 1: read-address channel
- `RDATA` out DATA_W; `RRESP` out 1; `RVALID` out 1; `RREADY` in 1: read-data channel
- `PADDR` out ADDR_W; `PSEL`, `PENABLE`, `PWRITE` out 1; `PWDATA` out DATA_W; `PSTRB` out DATA_W/8: APB request
- `PRDATA` in DATA_W; `PREADY` in 1; `PSLVERR` in 1: APB completion

## Operation
- **FSM states:** IDLE, SETUP, ACCESS, WRESP, RRESP.
- **Write capture:** AW and W are captured independently into `aw_hold`/`w_hold` registers, in either order.
  - `AWREADY` = IDLE & !aw_hold; `WREADY` = IDLE & !w_hold.
- **Read acceptance:** `ARREADY` = IDLE & !aw_hold & !w_hold & !AWVALID & !WVALID. Writes have strict priority.
- **IDLE exits:**
  - To SETUP (write) when aw_hold & w_hold are both set.
  - To SETUP (read) on an AR handshake.
- **SETUP:** PSEL=1, PENABLE=0. PADDR, PWRITE, PWDATA and PSTRB come from the latched values; reads drive PSTRB=0 and PWDATA=0. Lasts exactly one cycle, then ACCESS.
- **ACCESS:** PSEL=1, PENABLE=1. Holds until PREADY=1 is sampled.
  - Write: BRESP <= PSLVERR, then go to WRESP.
  - Read: RDATA <= PRDATA and RRESP <= PSLVERR, then go to RRESP.
- **WRESP:** BVALID=1 until BREADY=1 is sampled. Then clear aw_hold/w_hold and return to IDLE.
- **RRESP:** RVALID=1 until RREADY=1 is sampled, then return to IDLE.
- **Address handling:** PADDR is passed through unmodified, with no alignment or decode.
- **Ordering:** only one transaction is outstanding at a time, so responses are strictly in acceptance order.

## Timing
- **Reset state:** while ARESET=0, every output is 0 and the FSM is in IDLE.
  - Ready signals are gated by a registered `rst_done` flag, so AWREADY, WREADY and ARREADY first rise on the first cycle after release.
- **Zero-wait write:** with the final AW/W handshake at edge N, PSEL rises after N, PENABLE after N+1, and BVALID after N+2 (3 cycles from handshake to response).
- **Zero-wait read:** handshake at N, RVALID after N+2.
- **Wait states:** each PREADY=0 cycle in ACCESS adds one cycle of latency.
- **Stable payloads:**
  - PADDR, PWRITE, PWDATA and PSTRB stay constant from SETUP through the end of ACCESS.
  - RDATA/RRESP and BRESP stay constant while their VALID is high.
- **Back-to-back:** AWREADY/WREADY/ARREADY reassert on the cycle after the B or R handshake.
- **Reset mid-transfer:** PSEL, PENABLE and all VALIDs drop asynchronously. The pending transaction is discarded and no response is produced.
- **Response errors:** PSLVERR is sampled only when PENABLE & PREADY; it is ignored in all other cycles.

## Configuration
- Macro: `AXI_APB_TIMEOUT_EN`.
- **Defined:**
  - A counter clears on SETUP entry and increments every ACCESS cycle with PREADY=0.
  - Once it reaches TIMEOUT, the bridge ends the transfer: PSEL/PENABLE deassert on the next edge.
  - The response is error=1; a read also returns RDATA=0.
- **Undefined:** ACCESS waits indefinitely for PREADY, and TIMEOUT is unused.

## Structure
- Package `axi_apb_pkg` holds:
  - the FSM state enum;
  - `RESP_OKAY=1'b0` and `RESP_SLVERR=1'b1`.
- Sub-module `apb_timeout_cnt` holds the counter and compare, and is instantiated only under `AXI_APB_TIMEOUT_EN`.

## Test plan
1. **Single write:** AWADDR=0x10, WDATA=0x12345678, WSTRB=0001, PREADY=1, with AW and W handshaking together at N → SETUP after N with PADDR=0x10 and PSTRB=0001; PENABLE after N+1; BVALID after N+2 with BRESP=0.
2. **Split write:** AW handshakes 2 cycles before W → AWREADY=0 after the AW handshake; PSEL rises only on the cycle after the W handshake.
3. **Read with wait states:** ARADDR=0x20, PRDATA=0xCAFEF00D, PREADY low for 3 ACCESS cycles, RREADY=0 for 5 cycles → RVALID=1 with RDATA=0xCAFEF00D and RRESP=0, stable for all 5 cycles.
4. **Simultaneous requests:** AWVALID, WVALID and ARVALID asserted together in IDLE → the write is performed first; ARREADY stays 0 until after the B handshake, then the read completes.
5. **Slave error:** PSLVERR=1 with PREADY on a write → BRESP=1; the next write with PSLVERR=0 → BRESP=0.
6. **Timeout and reset:**
   - With the macro defined and TIMEOUT=16, PREADY held 0 → PSEL drops after 16 ACCESS cycles and BRESP=1.
   - ARESET=0 during ACCESS → PSEL, PENABLE and all VALIDs are 0 immediately, with no response afterwards.

Source files
------------

// File: rtl/axi_apb_pkg.sv
// Shared types and constants for the AXI4-Lite to APB4 bridge.
// Contents: FSM state enum and the one-bit AXI response encodings.
package axi_apb_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS,
      S_WRESP,
      S_RRESP
   } state_e;

   localparam logic RESP_OKAY   = 1'b0;
   localparam logic RESP_SLVERR = 1'b1;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase watchdog for the AXI-to-APB bridge.
// The module only exists when AXI_APB_TIMEOUT_EN is defined; without the
// macro the bridge waits indefinitely for PREADY and nothing here is built.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clear_i     - SETUP cycle, restarts the count
//   count_i     - ACCESS cycle with PREADY low
//   expired_o   - this stalled cycle brings the count to TIMEOUT
`ifdef AXI_APB_TIMEOUT_EN
module apb_timeout_cnt #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic count_i,
   output logic expired_o
);
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (count_i) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Fires on the stalled cycle whose increment reaches TIMEOUT, so the
   // transfer ends on that edge after exactly TIMEOUT ACCESS cycles.
   assign expired_o = count_i && (cnt_q == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`endif

// File: rtl/axi_apb_bridge.sv
// AXI4-Lite slave to APB4 master bridge. Each single-beat AXI write or read
// becomes exactly one APB SETUP/ACCESS transfer; PSLVERR is returned as the
// AXI response. One transaction is outstanding at a time, writes win.
// Optional ACCESS watchdog: define AXI_APB_TIMEOUT_EN.
// Ports:
//   ACLK, ARESET            - clock, asynchronous active-low reset
//   AW*/W*/B*               - AXI write address, data, response
//   AR*/R*                  - AXI read address, data
//   PADDR..PSTRB            - APB request (registered)
//   PRDATA, PREADY, PSLVERR - APB completion
//
// state    | meaning
// S_IDLE   | collect AW/W into hold regs, or accept AR
// S_SETUP  | PSEL=1, PENABLE=0, one cycle
// S_ACCESS | PSEL=1, PENABLE=1 until PREADY (or watchdog)
// S_WRESP  | BVALID until BREADY
// S_RRESP  | RVALID until RREADY
module axi_apb_bridge
   import axi_apb_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                ACLK,
   input  logic                ARESET,
   input  logic [ADDR_W-1:0]   AWADDR,
   input  logic                AWVALID,
   output logic                AWREADY,
   input  logic [DATA_W-1:0]   WDATA,
   input  logic [DATA_W/8-1:0] WSTRB,
   input  logic                WVALID,
   output logic                WREADY,
   output logic                BRESP,
   output logic                BVALID,
   input  logic                BREADY,
   input  logic [ADDR_W-1:0]   ARADDR,
   input  logic                ARVALID,
   output logic                ARREADY,
   output logic [DATA_W-1:0]   RDATA,
   output logic                RRESP,
   output logic                RVALID,
   input  logic                RREADY,
   output logic [ADDR_W-1:0]   PADDR,
   output logic                PSEL,
   output logic                PENABLE,
   output logic                PWRITE,
   output logic [DATA_W-1:0]   PWDATA,
   output logic [DATA_W/8-1:0] PSTRB,
   input  logic [DATA_W-1:0]   PRDATA,
   input  logic                PREADY,
   input  logic                PSLVERR
);
   localparam int unsigned STRB_W = DATA_W / 8;

   state_e              state_q, state_d;
   logic                rst_done_q;
   logic                aw_hold_q, aw_hold_d, w_hold_q, w_hold_d;
   logic [ADDR_W-1:0]   aw_addr_q, aw_addr_d;
   logic [DATA_W-1:0]   w_data_q, w_data_d;
   logic [STRB_W-1:0]   w_strb_q, w_strb_d;
   logic [ADDR_W-1:0]   paddr_q, paddr_d;
   logic                psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
   logic [DATA_W-1:0]   pwdata_q, pwdata_d;
   logic [STRB_W-1:0]   pstrb_q, pstrb_d;
   logic                bvalid_q, bvalid_d, bresp_q, bresp_d;
   logic                rvalid_q, rvalid_d, rresp_q, rresp_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                idle, aw_hs, w_hs, ar_hs, tmo_expired;

   assign idle    = rst_done_q && (state_q == S_IDLE);
   assign AWREADY = idle && !aw_hold_q;
   assign WREADY  = idle && !w_hold_q;
   assign ARREADY = idle && !aw_hold_q && !w_hold_q && !AWVALID && !WVALID;
   assign aw_hs   = AWVALID && AWREADY;
   assign w_hs    = WVALID && WREADY;
   assign ar_hs   = ARVALID && ARREADY;

`ifdef AXI_APB_TIMEOUT_EN
   apb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
      .clk       (ACLK),
      .rst_n     (ARESET),
      .clear_i   (state_q == S_SETUP),
      .count_i   ((state_q == S_ACCESS) && !PREADY),
      .expired_o (tmo_expired)
   );
`else
   // No watchdog: TIMEOUT has no effect, it is only referenced so both
   // builds share one parameter list.
   assign tmo_expired = 1'b0 & (TIMEOUT == 0);
`endif

   always_comb begin
      state_d   = state_q;
      aw_hold_d = aw_hold_q;
      w_hold_d  = w_hold_q;
      aw_addr_d = aw_addr_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      paddr_d   = paddr_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      pwrite_d  = pwrite_q;
      pwdata_d  = pwdata_q;
      pstrb_d   = pstrb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      rvalid_d  = rvalid_q;
      rresp_d   = rresp_q;
      rdata_d   = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (aw_hs) begin
               aw_hold_d = 1'b1;
               aw_addr_d = AWADDR;
            end
            if (w_hs) begin
               w_hold_d = 1'b1;
               w_data_d = WDATA;
               w_strb_d = WSTRB;
            end
            // Launch on the edge completing the pair, so PSEL follows the
            // last handshake directly rather than a cycle later.
            if ((aw_hold_q || aw_hs) && (w_hold_q || w_hs)) begin
               state_d  = S_SETUP;
               psel_d   = 1'b1;
               pwrite_d = 1'b1;
               paddr_d  = aw_hold_q ? aw_addr_q : AWADDR;
               pwdata_d = w_hold_q ? w_data_q : WDATA;
               pstrb_d  = w_hold_q ? w_strb_q : WSTRB;
            end else if (ar_hs) begin
               state_d  = S_SETUP;
               psel_d   = 1'b1;
               pwrite_d = 1'b0;
               paddr_d  = ARADDR;
               pwdata_d = '0;
               pstrb_d  = '0;
            end
         end
         S_SETUP: begin
            penable_d = 1'b1;
            state_d   = S_ACCESS;
         end
         S_ACCESS: begin
            if (PREADY || tmo_expired) begin
               psel_d    = 1'b0;
               penable_d = 1'b0;
               if (pwrite_q) begin
                  bresp_d  = PREADY ? PSLVERR : RESP_SLVERR;
                  bvalid_d = 1'b1;
                  state_d  = S_WRESP;
               end else begin
                  rdata_d  = PREADY ? PRDATA : '0;
                  rresp_d  = PREADY ? PSLVERR : RESP_SLVERR;
                  rvalid_d = 1'b1;
                  state_d  = S_RRESP;
               end
            end
         end
         S_WRESP: begin
            if (BREADY) begin
               bvalid_d  = 1'b0;
               aw_hold_d = 1'b0;
               w_hold_d  = 1'b0;
               state_d   = S_IDLE;
            end
         end
         S_RRESP: begin
            if (RREADY) begin
               rvalid_d = 1'b0;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESET) begin
      if (!ARESET) begin
         state_q    <= S_IDLE;
         rst_done_q <= 1'b0;
         aw_hold_q  <= 1'b0;
         w_hold_q   <= 1'b0;
         aw_addr_q  <= '0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         paddr_q    <= '0;
         psel_q     <= 1'b0;
         penable_q  <= 1'b0;
         pwrite_q   <= 1'b0;
         pwdata_q   <= '0;
         pstrb_q    <= '0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         rvalid_q   <= 1'b0;
         rresp_q    <= RESP_OKAY;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         rst_done_q <= 1'b1;
         aw_hold_q  <= aw_hold_d;
         w_hold_q   <= w_hold_d;
         aw_addr_q  <= aw_addr_d;
         w_data_q   <= w_data_d;
         w_strb_q   <= w_strb_d;
         paddr_q    <= paddr_d;
         psel_q     <= psel_d;
         penable_q  <= penable_d;
         pwrite_q   <= pwrite_d;
         pwdata_q   <= pwdata_d;
         pstrb_q    <= pstrb_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         rvalid_q   <= rvalid_d;
         rresp_q    <= rresp_d;
         rdata_q    <= rdata_d;
      end
   end

   assign PADDR   = paddr_q;
   assign PSEL    = psel_q;
   assign PENABLE = penable_q;
   assign PWRITE  = pwrite_q;
   assign PWDATA  = pwdata_q;
   assign PSTRB   = pstrb_q;
   assign BVALID  = bvalid_q;
   assign BRESP   = bresp_q;
   assign RVALID  = rvalid_q;
   assign RRESP   = rresp_q;
   assign RDATA   = rdata_q;

endmodule

// File: tb/tb_axi_apb_bridge.sv
// Self-checking bench for axi_apb_bridge: directed scenarios plus randomized
// single transactions. Expected APB fields, latencies and responses come from
// the transaction parameters each task is given.
module tb_axi_apb_bridge;
   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 16;

   logic        ACLK = 1'b0;
   logic        ARESET = 1'b0;
   logic [31:0] AWADDR = '0, WDATA = '0, ARADDR = '0, RDATA, PADDR, PWDATA;
   logic [31:0] PRDATA = '0;
   logic [3:0]  WSTRB = '0, PSTRB;
   logic        AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b0, ARVALID = 1'b0, RREADY = 1'b0;
   logic        AWREADY, WREADY, BRESP, BVALID, ARREADY, RRESP, RVALID;
   logic        PSEL, PENABLE, PWRITE;
   logic        PREADY = 1'b0, PSLVERR = 1'b0;

   int          n_vec = 0, n_err = 0;

   logic [31:0] exp_paddr = '0, exp_pwdata = '0;
   logic [3:0]  exp_pstrb = '0;
   logic        exp_pwrite = 1'b0;
   bit          chk_apb = 1'b0;

   int          slv_waits = 0, acc_cnt = 0;
   logic [31:0] slv_prdata = '0;
   bit          slv_err = 1'b0, slv_hang = 1'b0;

   axi_apb_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
      .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PWDATA(PWDATA), .PSTRB(PSTRB),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   always #5 ACLK = ~ACLK;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%h, want 0x%h", tag, act, exp);
      end
   endtask

   // APB peripheral: PREADY after slv_waits stalled ACCESS cycles; noise on
   // PREADY/PSLVERR/PRDATA whenever no transfer is completing.
   always @(posedge ACLK) begin
      #1;
      if (PSEL && PENABLE) begin
         PREADY  = !slv_hang && (acc_cnt >= slv_waits);
         PRDATA  = PREADY ? slv_prdata : $urandom;
         PSLVERR = PREADY ? slv_err : 1'($urandom_range(0, 1));
         acc_cnt++;
      end else begin
         acc_cnt = 0;
         PREADY  = 1'($urandom_range(0, 1));
         PSLVERR = 1'($urandom_range(0, 1));
         PRDATA  = $urandom;
      end
   end

   // APB payload must match the accepted request for the whole transfer;
   // reads may not be accepted while any write activity is visible.
   always @(negedge ACLK) begin
      if (ARESET) begin
         if (chk_apb && PSEL) begin
            chk("apb_paddr", PADDR, exp_paddr);
            chk("apb_pwrite", PWRITE, exp_pwrite);
            chk("apb_pwdata", PWDATA, exp_pwdata);
            chk("apb_pstrb", PSTRB, exp_pstrb);
         end
         if (ARVALID && (AWVALID || WVALID || PSEL || BVALID))
            chk("ar_blocked", ARREADY, 1'b0);
      end
   end

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int waits, input int bready_dly,
                           input bit err, input bit with_ar);
      int cyc;
      bit aw_done, w_done;
      cyc = 0; aw_done = 0; w_done = 0;
      exp_paddr = addr; exp_pwrite = 1'b1; exp_pwdata = data; exp_pstrb = strb; chk_apb = 1'b1;
      slv_waits = waits; slv_err = err; slv_prdata = $urandom;
      while (!(aw_done && w_done)) begin
         @(posedge ACLK); #1;
         if (cyc >= 100) break;
         AWADDR  = aw_done ? $urandom : addr;
         WDATA   = w_done ? $urandom : data;
         WSTRB   = w_done ? 4'($urandom) : strb;
         AWVALID = !aw_done && (cyc >= aw_dly);
         WVALID  = !w_done && (cyc >= w_dly);
         if (with_ar) ARVALID = 1'b1;
         @(negedge ACLK);
         if (aw_done && !w_done) begin
            chk("awready_held", AWREADY, 1'b0);
            chk("psel_wait_w", PSEL, 1'b0);
         end
         if (w_done && !aw_done) begin
            chk("wready_held", WREADY, 1'b0);
            chk("psel_wait_aw", PSEL, 1'b0);
         end
         if (AWVALID && AWREADY) aw_done = 1;
         if (WVALID && WREADY) w_done = 1;
         cyc++;
      end
      if (!(aw_done && w_done)) begin
         chk("aw_w_budget", {30'd0, aw_done, w_done}, 32'd3);
         AWVALID = 0; WVALID = 0;
         return;
      end
      @(posedge ACLK); #1;
      AWVALID = 0; WVALID = 0; AWADDR = $urandom; WDATA = $urandom;
      @(negedge ACLK);
      chk("wr_setup_psel", PSEL, 1'b1);
      chk("wr_setup_penable", PENABLE, 1'b0);
      chk("wr_setup_paddr", PADDR, addr);
      chk("wr_setup_pstrb", PSTRB, strb);
      @(posedge ACLK); #1;
      @(negedge ACLK);
      chk("wr_access_penable", PENABLE, 1'b1);
      chk("wr_access_bvalid", BVALID, 1'b0);
      for (int i = 0; i < waits; i++) begin
         @(posedge ACLK); #1;
         @(negedge ACLK);
         chk("wr_wait_penable", PENABLE, 1'b1);
         chk("wr_wait_bvalid", BVALID, 1'b0);
      end
      @(posedge ACLK); #1;
      BREADY = (bready_dly == 0);
      cyc = 0;
      forever begin
         @(negedge ACLK);
         chk("bvalid", BVALID, 1'b1);
         chk("bresp", BRESP, err);
         chk("b_psel", PSEL, 1'b0);
         if (BREADY) break;
         @(posedge ACLK); #1;
         cyc++;
         BREADY = (cyc >= bready_dly);
      end
      @(posedge ACLK); #1;
      BREADY = 0;
      @(negedge ACLK);
      chk("b_done", BVALID, 1'b0);
      chk("awready_again", AWREADY, 1'b1);
      chk("wready_again", WREADY, 1'b1);
      chk("arready_again", ARREADY, 1'b1);
   endtask

   task automatic do_read(input logic [31:0] addr, input int ar_dly, input int waits,
                          input int rready_dly, input logic [31:0] prdata, input bit err);
      int cyc;
      bit ar_done;
      exp_paddr = addr; exp_pwrite = 1'b0; exp_pwdata = '0; exp_pstrb = '0; chk_apb = 1'b1;
      slv_waits = waits; slv_err = err; slv_prdata = prdata;
      cyc = 0;
      ar_done = ARVALID && ARREADY;
      while (!ar_done) begin
         @(posedge ACLK); #1;
         if (cyc >= 100) break;
         ARADDR  = addr;
         ARVALID = (cyc >= ar_dly);
         @(negedge ACLK);
         if (ARVALID && ARREADY) ar_done = 1;
         cyc++;
      end
      if (!ar_done) begin
         chk("ar_budget", {31'd0, ar_done}, 32'd1);
         ARVALID = 0;
         return;
      end
      @(posedge ACLK); #1;
      ARVALID = 0; ARADDR = $urandom;
      @(negedge ACLK);
      chk("rd_setup_psel", PSEL, 1'b1);
      chk("rd_setup_penable", PENABLE, 1'b0);
      chk("rd_setup_paddr", PADDR, addr);
      chk("rd_setup_pstrb", PSTRB, 4'h0);
      chk("rd_setup_pwdata", PWDATA, 32'h0);
      @(posedge ACLK); #1;
      @(negedge ACLK);
      chk("rd_access_penable", PENABLE, 1'b1);
      chk("rd_access_rvalid", RVALID, 1'b0);
      for (int i = 0; i < waits; i++) begin
         @(posedge ACLK); #1;
         @(negedge ACLK);
         chk("rd_wait_penable", PENABLE, 1'b1);
         chk("rd_wait_rvalid", RVALID, 1'b0);
      end
      @(posedge ACLK); #1;
      RREADY = (rready_dly == 0);
      cyc = 0;
      forever begin
         @(negedge ACLK);
         chk("rvalid", RVALID, 1'b1);
         chk("rdata", RDATA, prdata);
         chk("rresp", RRESP, err);
         if (RREADY) break;
         @(posedge ACLK); #1;
         cyc++;
         RREADY = (cyc >= rready_dly);
      end
      @(posedge ACLK); #1;
      RREADY = 0;
      @(negedge ACLK);
      chk("r_done", RVALID, 1'b0);
      chk("arready_after_r", ARREADY, 1'b1);
      chk("awready_after_r", AWREADY, 1'b1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // Reset state
      repeat (2) @(negedge ACLK);
      chk("rst_psel", PSEL, 1'b0);
      chk("rst_penable", PENABLE, 1'b0);
      chk("rst_bvalid", BVALID, 1'b0);
      chk("rst_rvalid", RVALID, 1'b0);
      chk("rst_awready", AWREADY, 1'b0);
      chk("rst_wready", WREADY, 1'b0);
      chk("rst_arready", ARREADY, 1'b0);
      chk("rst_paddr", PADDR, 32'h0);
      chk("rst_rdata", RDATA, 32'h0);
      chk("rst_pstrb", PSTRB, 4'h0);
      @(posedge ACLK); #2;
      ARESET = 1'b1;
      @(negedge ACLK);
      chk("rdy_first_cycle", {AWREADY, WREADY, ARREADY}, 3'b000);
      @(posedge ACLK); #1;
      @(negedge ACLK);
      chk("rdy_after_release", {AWREADY, WREADY, ARREADY}, 3'b111);

      // Single write, then split writes in both orders
      do_write(32'h10, 32'h12345678, 4'b0001, 0, 0, 0, 0, 1'b0, 1'b0);
      do_write(32'h14, 32'hA5A5_0F0F, 4'b1100, 0, 2, 1, 1, 1'b0, 1'b0);
      do_write(32'h18, 32'h0BAD_BEEF, 4'b1111, 3, 0, 0, 2, 1'b0, 1'b0);

      // Read with wait states and a slow master
      do_read(32'h20, 0, 3, 5, 32'hCAFEF00D, 1'b0);

      // Simultaneous requests: write first, read after the B handshake
      ARADDR = 32'h44;
      do_write(32'h40, 32'h1111_2222, 4'b1010, 0, 0, 2, 1, 1'b0, 1'b1);
      do_read(32'h44, 0, 0, 0, 32'h3333_4444, 1'b0);

      // Slave error, then clean write
      do_write(32'h50, 32'hDEAD_0001, 4'b0011, 0, 0, 0, 0, 1'b1, 1'b0);
      do_write(32'h54, 32'hDEAD_0002, 4'b0011, 0, 0, 0, 0, 1'b0, 1'b0);
      do_read(32'h58, 1, 1, 0, 32'h7777_8888, 1'b1);

`ifdef AXI_APB_TIMEOUT_EN
      slv_hang = 1'b1;
      do_write(32'h80, 32'h8080_8080, 4'b1111, 0, 0, TIMEOUT - 1, 0, 1'b1, 1'b0);
      do_read(32'h84, 0, TIMEOUT - 1, 1, 32'h0, 1'b1);
      slv_hang = 1'b0;
`else
      do_write(32'h80, 32'h8080_8080, 4'b1111, 0, 0, 40, 0, 1'b0, 1'b0);
`endif

      // Reset during ACCESS: everything drops at once, no response follows
      exp_paddr = 32'h90; exp_pwrite = 1'b1; exp_pwdata = 32'h5A5A5A5A; exp_pstrb = 4'hF;
      slv_hang = 1'b1;
      @(posedge ACLK); #1;
      AWADDR = 32'h90; WDATA = 32'h5A5A5A5A; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
      @(posedge ACLK); #1;
      AWVALID = 0; WVALID = 0;
      @(posedge ACLK); #1;
      @(negedge ACLK);
      chk("rst_mid_in_access", PENABLE, 1'b1);
      @(posedge ACLK); #3;
      ARESET = 1'b0;
      #1;
      chk("rst_mid_psel", PSEL, 1'b0);
      chk("rst_mid_penable", PENABLE, 1'b0);
      chk("rst_mid_valids", {BVALID, RVALID}, 2'b00);
      chk("rst_mid_readies", {AWREADY, WREADY, ARREADY}, 3'b000);
      @(posedge ACLK); #2;
      ARESET = 1'b1;
      slv_hang = 1'b0;
      @(negedge ACLK);
      chk("rst_mid_first_cycle", AWREADY, 1'b0);
      for (int i = 0; i < 6; i++) begin
         @(posedge ACLK); #1;
         @(negedge ACLK);
         chk("rst_mid_no_resp", {BVALID, RVALID, PSEL}, 3'b000);
      end
      chk("rst_mid_holds_clear", {AWREADY, WREADY}, 2'b11);

      // Randomized single transactions
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 1) == 1)
            do_write($urandom, $urandom, 4'($urandom), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                     int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), 1'b0);
         else
            do_read($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 3) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
